clut_cache: RTL and testbench

Colour-lookup-table cache for the texture path. Fetches a 16-entry (4bpp) or 256-entry (8bpp) CLUT from VRAM on request. Serves two independent 1-cycle-latency lookup ports, one per pixel lane, to the texel-to-RGB stages sitting directly downstream. Tracks the resident CLUT key, so a repeated load of the same CLUT costs no VRAM traffic.

---
 rtl/clut_cache_pkg.sv | 32 +++
 rtl/clut_cache_ram.sv | 35 +++
 rtl/clut_cache.sv | 182 ++++++++++++++++++
 tb/tb_clut_cache.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clut_cache_pkg.sv
// Shared GPU texture-path definitions: pixel-format encodings, CLUT sizes,
// CLUT cache FSM states and the resident-CLUT key.
package clut_cache_pkg;

  localparam logic [1:0] PIX_4BIT  = 2'd0;
  localparam logic [1:0] PIX_8BIT  = 2'd1;
  localparam logic [1:0] PIX_16BIT = 2'd2;

  localparam int CLUT_WORDS_4BPP = 8;
  localparam int CLUT_WORDS_8BPP = 128;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } clutState_e;

  typedef struct packed {
    logic [8:0] y;
    logic [5:0] x;
    logic       is8;
  } clutKey_t;

  function automatic logic [7:0] clutWords(input logic is8);
    return is8 ? 8'(CLUT_WORDS_8BPP) : 8'(CLUT_WORDS_4BPP);
  endfunction

  // X is in 16-pixel units (8 words); the sum wraps within the 512-word line.
  function automatic logic [8:0] clutXword(input logic [5:0] x, input logic [6:0] w);
    return {x, 3'b000} + {2'b00, w};
  endfunction

endpackage

// File: rtl/clut_cache_ram.sv
// 128 x 32-bit CLUT storage: one write port, one registered read port.
// Only the read register is reset; the array contents are not.
module clut_ram_128x32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [6:0]  wAddr,
  input  logic [31:0] wData,
  input  logic        rEn,
  input  logic [6:0]  rAddr,
  output logic [31:0] rData
);

  logic [31:0] mem_r [0:127];
  logic [31:0] rData_r;

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[wAddr] <= wData;
    end
  end

  // Registered read port; holds its value when no read is requested
  always_ff @(posedge clk) begin
    if (rst) begin
      rData_r <= 32'd0;
    end else if (rEn) begin
      rData_r <= mem_r[rAddr];
    end
  end

  assign rData = rData_r;

endmodule

// File: rtl/clut_cache.sv
// CLUT cache: fetches a 4bpp/8bpp colour table from VRAM on a key miss and
// serves two independent 1-cycle lookup lanes from duplicated storage.
module clut_cache
  import clut_cache_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_loadClut,
  input  logic [5:0]  i_clutX,
  input  logic [8:0]  i_clutY,
  input  logic        i_clut8bpp,
  input  logic        i_invalidate,
  output logic        o_ready,
  output logic        o_memReq,
  output logic [17:0] o_memAddr,
  input  logic        i_memAck,
  input  logic        i_memDataValid,
  input  logic [31:0] i_memData,
  input  logic        i_lookupValidA,
  input  logic [7:0]  i_indexA,
  input  logic        i_lookupValidB,
  input  logic [7:0]  i_indexB,
  output logic [15:0] o_clutA,
  output logic        o_clutValidA,
  output logic [15:0] o_clutB,
  output logic        o_clutValidB
);

  clutState_e  state_r;
  clutKey_t    key_r;
  logic        valid_r;
  logic        pending_r;
  logic [7:0]  issueCnt_r;
  logic [6:0]  rcvCnt_r;
  logic [3:0]  inFlight_r;
  logic        ready_r;
  logic        memReq_r;
  logic [17:0] memAddr_r;
  logic        idx0A_r;
  logic        idx0B_r;
  logic        clutValidA_r;
  logic        clutValidB_r;

  logic [7:0]  totalWords_s;
  logic        ackFire_s;
  logic        dataFire_s;
  logic [7:0]  issueNext_s;
  logic [3:0]  inFlightNext_s;
  logic        lastWord_s;
  logic        reqNext_s;
  logic        loadHit_s;
  logic [31:0] ramDataA_s;
  logic [31:0] ramDataB_s;

  // Load bookkeeping: handshakes, next counter values, hit detection
  always_comb begin
    totalWords_s   = clutWords(key_r.is8);
    ackFire_s      = memReq_r & i_memAck;
    if (state_r == ST_LOAD) begin
      dataFire_s = i_memDataValid;
    end else begin
      dataFire_s = 1'b0;
    end
    issueNext_s    = issueCnt_r + {7'd0, ackFire_s};
    inFlightNext_s = inFlight_r + {3'd0, ackFire_s} - {3'd0, dataFire_s};
    lastWord_s     = dataFire_s & (rcvCnt_r == 7'(totalWords_s - 8'd1));
    reqNext_s      = ~lastWord_s & (issueNext_s < totalWords_s)
                   & (inFlightNext_s < 4'(MAX_OUTSTANDING));
    // A coinciding invalidate wins, so the load becomes a miss
    loadHit_s      = valid_r & ~i_invalidate & (key_r.y == i_clutY)
                   & (key_r.x == i_clutX) & (key_r.is8 | ~i_clut8bpp);
  end

  // Residency / load FSM with registered memory-request outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      key_r      <= '0;
      valid_r    <= 1'b0;
      pending_r  <= 1'b0;
      issueCnt_r <= 8'd0;
      rcvCnt_r   <= 7'd0;
      inFlight_r <= 4'd0;
      ready_r    <= 1'b1;
      memReq_r   <= 1'b0;
      memAddr_r  <= 18'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_loadClut && !loadHit_s) begin
            key_r      <= '{y: i_clutY, x: i_clutX, is8: i_clut8bpp};
            valid_r    <= 1'b0;
            pending_r  <= 1'b0;
            issueCnt_r <= 8'd0;
            rcvCnt_r   <= 7'd0;
            inFlight_r <= 4'd0;
            ready_r    <= 1'b0;
            memReq_r   <= 1'b0;
            state_r    <= ST_LOAD;
          end else if (i_invalidate) begin
            valid_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          issueCnt_r <= issueNext_s;
          inFlight_r <= inFlightNext_s;
          memReq_r   <= reqNext_s;
          if (reqNext_s) begin
            memAddr_r <= {key_r.y, clutXword(key_r.x, issueNext_s[6:0])};
          end
          if (dataFire_s) begin
            rcvCnt_r <= rcvCnt_r + 7'd1;
          end
          if (i_invalidate) begin
            pending_r <= 1'b1;
          end
          if (lastWord_s) begin
            valid_r  <= ~(pending_r | i_invalidate);
            ready_r  <= 1'b1;
            memReq_r <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Lookup side: valid flags and the half-word selects follow the read register
  always_ff @(posedge clk) begin
    if (rst) begin
      idx0A_r      <= 1'b0;
      idx0B_r      <= 1'b0;
      clutValidA_r <= 1'b0;
      clutValidB_r <= 1'b0;
    end else begin
      clutValidA_r <= i_lookupValidA;
      clutValidB_r <= i_lookupValidB;
      if (i_lookupValidA) begin
        idx0A_r <= i_indexA[0];
      end
      if (i_lookupValidB) begin
        idx0B_r <= i_indexB[0];
      end
    end
  end

  clut_ram_128x32 u_ramA (
    .clk   (clk),
    .rst   (rst),
    .we    (dataFire_s),
    .wAddr (rcvCnt_r),
    .wData (i_memData),
    .rEn   (i_lookupValidA),
    .rAddr (i_indexA[7:1]),
    .rData (ramDataA_s)
  );

  clut_ram_128x32 u_ramB (
    .clk   (clk),
    .rst   (rst),
    .we    (dataFire_s),
    .wAddr (rcvCnt_r),
    .wData (i_memData),
    .rEn   (i_lookupValidB),
    .rAddr (i_indexB[7:1]),
    .rData (ramDataB_s)
  );

  assign o_clutA      = idx0A_r ? ramDataA_s[31:16] : ramDataA_s[15:0];
  assign o_clutB      = idx0B_r ? ramDataB_s[31:16] : ramDataB_s[15:0];
  assign o_clutValidA = clutValidA_r;
  assign o_clutValidB = clutValidB_r;
  assign o_ready      = ready_r;
  assign o_memReq     = memReq_r;
  assign o_memAddr    = memAddr_r;

endmodule

// File: tb/tb_clut_cache.sv
// Self-checking bench for clut_cache: randomized memory timing and loads,
// checked against a key/residency model and an address-derived data model.
module tb_clut_cache;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_loadClut, i_clut8bpp, i_invalidate;
  logic [5:0]  i_clutX;
  logic [8:0]  i_clutY;
  logic        o_ready, o_memReq;
  logic [17:0] o_memAddr;
  logic        i_memAck, i_memDataValid;
  logic [31:0] i_memData;
  logic        i_lookupValidA, i_lookupValidB;
  logic [7:0]  i_indexA, i_indexB;
  logic [15:0] o_clutA, o_clutB;
  logic        o_clutValidA, o_clutValidB;

  always #5 clk = ~clk;

  clut_cache #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .i_loadClut(i_loadClut), .i_clutX(i_clutX), .i_clutY(i_clutY),
    .i_clut8bpp(i_clut8bpp), .i_invalidate(i_invalidate), .o_ready(o_ready),
    .o_memReq(o_memReq), .o_memAddr(o_memAddr), .i_memAck(i_memAck),
    .i_memDataValid(i_memDataValid), .i_memData(i_memData),
    .i_lookupValidA(i_lookupValidA), .i_indexA(i_indexA),
    .i_lookupValidB(i_lookupValidB), .i_indexB(i_indexB),
    .o_clutA(o_clutA), .o_clutValidA(o_clutValidA),
    .o_clutB(o_clutB), .o_clutValidB(o_clutValidB)
  );

  int total = 0;
  int bad = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Memory-side model state
  int          cyc = 0;
  int          latency = 3;
  int          ackPct = 100;
  int          stallLeft = 0;
  logic [31:0] dataQ[$];
  int          dueQ[$];
  logic        reqSeen = 1'b0, ackDriven = 1'b0, rstPrev = 1'b1;
  logic [17:0] addrSeen = 18'd0;
  int          accepted = 0, returned = 0, maxOut = 0, holdErr = 0;

  // Reference: expected key of the current load and resident-CLUT model
  logic [5:0]  expX = 6'd0;
  logic [8:0]  expY = 9'd0;
  int          expN = 0;
  logic [15:0] salt = 16'd0;
  bit          refValid = 1'b0;
  logic [5:0]  refX = 6'd0;
  logic [8:0]  refY = 9'd0;
  bit          ref8 = 1'b0;

  // Word k of the table (k = Xword offset from the CLUT start) holds entries 2k, 2k+1
  function automatic logic [31:0] memFn(input logic [17:0] a);
    logic [15:0] k;
    k = {7'd0, 9'(a[8:0] - {expX, 3'b000})};
    return {(k * 16'd2 + 16'd1) ^ salt, (k * 16'd2) ^ salt};
  endfunction

  function automatic logic [15:0] refEntry(input int i);
    return 16'(i) ^ salt;
  endfunction

  // Memory responder: random/stalled acks, in-order data after a fixed latency
  initial begin
    int xw;
    i_memAck = 1'b0;
    i_memDataValid = 1'b0;
    i_memData = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (reqSeen && ackDriven) begin
        xw = (int'(expX) * 8 + expN) % 512;
        checkVal("memAddr", {14'd0, addrSeen}, {14'd0, expY, 9'(xw)});
        expN++;
        dataQ.push_back(memFn(addrSeen));
        dueQ.push_back(cyc - 1 + latency);
        accepted++;
      end
      if (accepted - returned > maxOut) maxOut = accepted - returned;
      if (reqSeen && !ackDriven && !rstPrev && (o_memReq !== 1'b1 || o_memAddr !== addrSeen))
        holdErr++;
      rstPrev = rst;
      reqSeen = o_memReq;
      addrSeen = o_memAddr;
      ackDriven = (o_memReq === 1'b1) && !rst && (stallLeft == 0)
                  && ($urandom_range(99) < ackPct);
      if (o_memReq === 1'b1 && stallLeft > 0) stallLeft--;
      i_memAck = ackDriven;
      if (dueQ.size() > 0 && dueQ[0] <= cyc) begin
        i_memDataValid = 1'b1;
        i_memData = dataQ.pop_front();
        void'(dueQ.pop_front());
        returned++;
      end else begin
        i_memDataValid = 1'b0;
        i_memData = $urandom;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (o_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    checkVal({tag, "_loadDone"}, {31'd0, o_ready}, 32'd1);
  endtask

  task automatic pulseLoad(input logic [5:0] x, input logic [8:0] y, input logic is8,
                           input logic inv);
    expX = x;
    expY = y;
    expN = 0;
    i_clutX = x;
    i_clutY = y;
    i_clut8bpp = is8;
    i_invalidate = inv;
    i_loadClut = 1'b1;
    tick();
    i_loadClut = 1'b0;
    i_invalidate = 1'b0;
  endtask

  // Load through the residency model: hit -> no traffic, miss -> full fetch
  task automatic doLoad(input string tag, input logic [5:0] x, input logic [8:0] y,
                        input logic is8, input logic inv, input logic [15:0] newSalt);
    bit hit;
    int a0;
    int n;
    hit = !inv && refValid && refX == x && refY == y && (ref8 || !is8);
    if (!hit) salt = newSalt;
    a0 = accepted;
    pulseLoad(x, y, is8, inv);
    checkVal({tag, "_ready"}, {31'd0, o_ready}, {31'd0, hit});
    if (hit) begin
      n = 0;
      repeat (10) begin
        tick();
        if (o_ready !== 1'b1 || o_memReq !== 1'b0) n++;
      end
      checkVal({tag, "_idle"}, n, 0);
    end else begin
      waitReady(tag);
      refValid = 1'b1;
      refX = x;
      refY = y;
      ref8 = is8;
    end
    checkVal({tag, "_words"}, accepted - a0, hit ? 0 : (is8 ? 128 : 8));
  endtask

  task automatic checkLookups(input string tag);
    int ia, ib, n;
    logic [15:0] holdA, holdB;
    n = ref8 ? 256 : 16;
    for (int k = 0; k < 6; k++) begin
      ia = $urandom_range(n - 1);
      ib = $urandom_range(n - 1);
      i_lookupValidA = 1'b1;
      i_lookupValidB = 1'b1;
      i_indexA = 8'(ia);
      i_indexB = 8'(ib);
      tick();
      checkVal({tag, "_lkA"}, o_clutA, refEntry(ia));
      checkVal({tag, "_lkB"}, o_clutB, refEntry(ib));
    end
    holdA = refEntry(ia);
    holdB = refEntry(ib);
    i_lookupValidA = 1'b0;
    i_lookupValidB = 1'b0;
    i_indexA = ~i_indexA;
    i_indexB = ~i_indexB;
    tick();
    checkVal({tag, "_holdA"}, o_clutA, holdA);
    checkVal({tag, "_holdB"}, o_clutB, holdB);
    checkVal({tag, "_vld"}, {30'd0, o_clutValidA, o_clutValidB}, 32'd0);
  endtask

  initial begin
    int n;
    int viol;
    i_loadClut = 1'b0; i_clutX = 6'd0; i_clutY = 9'd0; i_clut8bpp = 1'b0;
    i_invalidate = 1'b0; i_lookupValidA = 1'b0; i_lookupValidB = 1'b0;
    i_indexA = 8'd0; i_indexB = 8'd0;
    rst = 1'b1;
    repeat (3) tick();
    checkVal("rst_ready", {31'd0, o_ready}, 32'd1);
    checkVal("rst_memReq", {31'd0, o_memReq}, 32'd0);
    checkVal("rst_memAddr", {14'd0, o_memAddr}, 32'd0);
    checkVal("rst_clut", {o_clutA, o_clutB}, 32'd0);
    checkVal("rst_vld", {30'd0, o_clutValidA, o_clutValidB}, 32'd0);
    rst = 1'b0;
    tick();

    // 4bpp miss, then a same-cycle dual-lane lookup
    latency = 3; ackPct = 100;
    doLoad("t1", 6'd3, 9'd480, 1'b0, 1'b0, 16'h0000);
    i_lookupValidA = 1'b1; i_indexA = 8'd5;
    i_lookupValidB = 1'b1; i_indexB = 8'd14;
    tick();
    checkVal("t1_idx5", o_clutA, 16'h0005);
    checkVal("t1_idx14", o_clutB, 16'h000E);
    checkVal("t1_vld", {30'd0, o_clutValidA, o_clutValidB}, 32'd3);
    i_lookupValidA = 1'b0; i_lookupValidB = 1'b0;
    tick();
    checkLookups("t1");

    // 8bpp load whose X wraps on the line
    doLoad("t2", 6'd60, 9'd100, 1'b1, 1'b0, 16'h0000);
    i_lookupValidA = 1'b1; i_indexA = 8'd255;
    tick();
    checkVal("t2_idx255", o_clutA, 16'h00FF);
    i_lookupValidA = 1'b0;
    checkLookups("t2");

    // Repeated load and 4bpp-after-8bpp are hits
    doLoad("t3a", 6'd60, 9'd100, 1'b1, 1'b0, 16'hFFFF);
    doLoad("t3b", 6'd60, 9'd100, 1'b0, 1'b0, 16'hFFFF);
    checkLookups("t3");

    // Ack stall then back-to-back acks with long data latency
    latency = 5; stallLeft = 20; maxOut = 0;
    doLoad("t4", 6'd33, 9'd511, 1'b1, 1'b0, 16'hA5A5);
    checkVal("t4_maxOut", maxOut, MAXO);
    checkLookups("t4");

    // Invalidate during a load leaves the CLUT non-resident
    latency = 4; salt = 16'h1234;
    pulseLoad(6'd5, 9'd200, 1'b0, 1'b0);
    checkVal("t5_ready", {31'd0, o_ready}, 32'd0);
    repeat (3) tick();
    i_invalidate = 1'b1;
    tick();
    i_invalidate = 1'b0;
    waitReady("t5");
    refValid = 1'b0; refX = 6'd5; refY = 9'd200; ref8 = 1'b0;
    doLoad("t5r", 6'd5, 9'd200, 1'b0, 1'b0, 16'h4321);
    checkLookups("t5");

    // Invalidate coinciding with a load of the resident key
    doLoad("t6", 6'd5, 9'd200, 1'b0, 1'b1, 16'h5555);
    checkLookups("t6");

    // Reset mid 8bpp load; late returns must be ignored
    latency = 6; ackPct = 70; salt = 16'h0F0F;
    pulseLoad(6'd10, 9'd7, 1'b1, 1'b0);
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkVal("t7_ready", {31'd0, o_ready}, 32'd1);
    checkVal("t7_memReq", {31'd0, o_memReq}, 32'd0);
    n = 0; viol = 0;
    while ((dueQ.size() > 0 || n < 3) && n < 100) begin
      tick();
      n++;
      if (o_ready !== 1'b1 || o_memReq !== 1'b0) viol++;
    end
    checkVal("t7_drained", dueQ.size(), 0);
    checkVal("t7_idle", viol, 0);
    refValid = 1'b0;
    doLoad("t7r", 6'd10, 9'd7, 1'b1, 1'b0, 16'h0F0F);
    checkLookups("t7");

    // Random loads with random memory timing
    for (int it = 0; it < 10; it++) begin
      logic [5:0] rx;
      logic [8:0] ry;
      if ($urandom_range(2) == 0) begin
        rx = refX; ry = refY;
      end else begin
        rx = 6'($urandom); ry = 9'($urandom);
      end
      ackPct = $urandom_range(100, 30);
      latency = $urandom_range(8, 1);
      doLoad("rnd", rx, ry, 1'($urandom), ($urandom_range(4) == 0), 16'($urandom));
      checkLookups("rnd");
    end

    checkVal("holdStable", holdErr, 0);
    checkVal("maxOutstanding", {31'd0, (maxOut <= MAXO)}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
